// File: rtl/jt12_div_multi.sv
// Multi-channel programmable clock-enable divider. Each channel divides cen
// (or the previous channel's tick when cascaded) by a run-time loadable ratio.
module jt12_div_multi #(
  parameter int              CH      = 4,
  parameter int              W       = 8,
  parameter logic [CH-1:0]   CASCADE = '0,
  parameter logic [W-1:0]    RST_DIV = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          wr,
  input  logic [3:0]    wr_ch,
  input  logic [W-1:0]  wr_div,
  input  logic          wr_now,
  input  logic          sync,
  output logic [CH-1:0] cen_out,
  output logic [CH-1:0] pending
);

  logic [CH-1:0] tick_vec;
  logic [CH-1:0] cen_out_reg;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic         src;
      logic         tick;
      logic         wrap;
      logic         wr_hit;
      logic [W-1:0] cnt_reg;
      logic [W-1:0] div_reg;
      logic [W-1:0] pend_val_reg;
      logic         pend_reg;

      // Cascaded channels take the previous channel's combinational tick,
      // so a chain of dividers adds no latency.
      if (gi > 0) begin : g_src
        if (CASCADE[gi]) begin : g_casc
          assign src = g_ch[gi-1].tick;
        end else begin : g_root
          assign src = cen;
        end
      end else begin : g_src0
        assign src = cen;
      end

      assign tick   = src && (cnt_reg == '0);
      assign wrap   = src && (cnt_reg == div_reg);
      assign wr_hit = wr && (wr_ch == 4'(gi));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg      <= '0;
          div_reg      <= RST_DIV;
          pend_val_reg <= '0;
          pend_reg     <= 1'b0;
        end else if (wr_hit && wr_now) begin
          div_reg  <= wr_div;
          cnt_reg  <= '0;
          pend_reg <= 1'b0;
        end else begin
          if (sync) begin
            cnt_reg <= '0;
          end else if (src) begin
            cnt_reg <= wrap ? '0 : cnt_reg + 1'b1;
          end
          // A wrap consumes the value that was already pending; a deferred
          // write landing on the same edge becomes the next pending value.
          if (wrap && pend_reg) begin
            div_reg  <= pend_val_reg;
            pend_reg <= 1'b0;
          end
          if (wr_hit) begin
            pend_val_reg <= wr_div;
            pend_reg     <= 1'b1;
          end
        end
      end

      assign tick_vec[gi] = tick;
      assign pending[gi]  = pend_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cen_out_reg <= '0;
    end else begin
      cen_out_reg <= tick_vec;
    end
  end

  assign cen_out = cen_out_reg;

endmodule

// File: tb/tb_jt12_div_multi.sv
// Directed bench for jt12_div_multi: CH=4, W=8, channels 1 and 2 cascaded,
// reset divide 0. Each cycle's outputs are compared one clock after driving.
module tb_jt12_div_multi;

  logic       clk = 1'b0;
  logic       rst_n, cen, wr, wr_now, sync;
  logic [3:0] wr_ch;
  logic [7:0] wr_div;
  logic [3:0] cen_out, pending;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic       rst_n;
    logic       cen;
    logic       wr;
    logic [3:0] wr_ch;
    logic [7:0] wr_div;
    logic       wr_now;
    logic       sync;
    logic [3:0] exp_out;
    logic [3:0] exp_pend;
    logic [3:0] mask;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  jt12_div_multi #(
    .CH(4), .W(8), .CASCADE(4'b0110), .RST_DIV(8'd0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .wr(wr), .wr_ch(wr_ch),
    .wr_div(wr_div), .wr_now(wr_now), .sync(sync),
    .cen_out(cen_out), .pending(pending)
  );

  function automatic vec_t mk(input logic r, input logic c, input logic w,
                              input logic [3:0] ch, input logic [7:0] d,
                              input logic now, input logic s,
                              input logic [3:0] eo, input logic [3:0] ep,
                              input logic [3:0] m);
    vec_t v;
    v.rst_n = r; v.cen = c; v.wr = w; v.wr_ch = ch; v.wr_div = d;
    v.wr_now = now; v.sync = s; v.exp_out = eo; v.exp_pend = ep; v.mask = m;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] got,
                       input logic [3:0] exp, input logic [3:0] m);
    total_cnt++;
    if ((got & m) === (exp & m)) pass_cnt++;
    else $display("FAIL %s got=%b exp=%b mask=%b", name, got, exp, m);
  endtask

  task automatic step(input string name, input vec_t v);
    rst_n = v.rst_n; cen = v.cen; wr = v.wr; wr_ch = v.wr_ch;
    wr_div = v.wr_div; wr_now = v.wr_now; sync = v.sync;
    @(posedge clk);
    #1;
    $display("%s: cen=%b wr=%b ch=%0d div=%0d now=%b sync=%b -> cen_out=%b pending=%b",
             name, v.cen, v.wr, v.wr_ch, v.wr_div, v.wr_now, v.sync, cen_out, pending);
    check($sformatf("%s_out", name), cen_out, v.exp_out, v.mask);
    check($sformatf("%s_pend", name), pending, v.exp_pend, 4'hf);
  endtask

  // Held-cen cycle, no writes, no sync.
  task automatic run(input string name, input logic [3:0] eo, input logic [3:0] m);
    step(name, mk(1, 1, 0, 0, 0, 0, 0, eo, 4'h0, m));
  endtask

  initial begin
    // Reset, then cen every 3 clks with every divider at 0.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hf));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hf));
    for (int i = 0; i < 2; i++) begin
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 4'hf, 4'h0, 4'hf));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hf));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hf));
    end
    // Deferred write ch0 = 5 while div=0: pending until the following wrap.
    tbl.push_back(mk(1, 1, 1, 0, 8'd5, 0, 0, 4'hf, 4'h1, 4'hf));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 4'hf, 4'h0, 4'hf));

    foreach (tbl[i]) step($sformatf("tbl%0d", i), tbl[i]);

    // New period of 6 on ch0; ch1/ch2 follow ch0, ch3 follows cen.
    for (int k = 0; k < 13; k++)
      run($sformatf("per6_%0d", k), (k % 6 == 0) ? 4'hf : 4'h8, 4'hf);

    // Cascade chain: ch0=11, ch1=5, ch2=1 loaded immediately with cen idle.
    step("ld0", mk(1, 0, 1, 0, 8'd11, 1, 0, 4'h0, 4'h0, 4'hf));
    step("ld1", mk(1, 0, 1, 1, 8'd5,  1, 0, 4'h0, 4'h0, 4'hf));
    step("ld2", mk(1, 0, 1, 2, 8'd1,  1, 0, 4'h0, 4'h0, 4'hf));
    for (int c = 0; c <= 144; c++) begin
      logic [3:0] e;
      e = {1'b1, c % 144 == 0, c % 72 == 0, c % 12 == 0};
      run($sformatf("casc_%0d", c), e, 4'hf);
    end

    // Immediate write ch3 = 2 at cnt=4 of div 7.
    step("ld3", mk(1, 0, 1, 3, 8'd7, 1, 0, 4'h0, 4'h0, 4'hf));
    for (int k = 0; k < 4; k++)
      run($sformatf("c3pre_%0d", k), (k == 0) ? 4'h8 : 4'h0, 4'h8);
    step("imm3", mk(1, 0, 1, 3, 8'd2, 1, 0, 4'h0, 4'h0, 4'hf));
    for (int k = 0; k < 7; k++)
      run($sformatf("c3post_%0d", k), (k % 3 == 0) ? 4'h8 : 4'h0, 4'h8);

    // Sync with channels out of phase, alongside an out-of-range write.
    step("sync0", mk(1, 0, 1, 4'd9, 8'd0, 1, 1, 4'h0, 4'h0, 4'hf));
    step("sync1", mk(1, 1, 0, 0, 0, 0, 1, 4'hf, 4'h0, 4'hf));
    for (int k = 0; k <= 12; k++) begin
      logic [3:0] e;
      e = {k % 3 == 0, k == 0, k == 0, k % 12 == 0};
      run($sformatf("align_%0d", k), e, 4'hf);
    end

    // Reset mid-period with a deferred write outstanding on ch1.
    step("defer1", mk(1, 0, 1, 1, 8'd3, 0, 0, 4'h0, 4'h2, 4'hf));
    step("mid0", mk(1, 1, 0, 0, 0, 0, 0, 4'h0, 4'h2, 4'hf));
    step("mid1", mk(1, 1, 0, 0, 0, 0, 0, 4'h0, 4'h2, 4'hf));
    step("rst",  mk(0, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hf));
    step("post0", mk(1, 1, 0, 0, 0, 0, 0, 4'hf, 4'h0, 4'hf));
    step("post1", mk(1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hf));
    step("post2", mk(1, 1, 0, 0, 0, 0, 0, 4'hf, 4'h0, 4'hf));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/jt12_div_multi.md
Name: jt12_div_multi

Overview:
- Parametrised, multi-channel successor to the fixed FM/SSG/ADPCM clock-enable divider.
- Produces CH independent clock-enable pulse trains from the master enable cen. Each channel has a run-time programmable divide ratio.
- Channels can be chained so one channel divides another's output, as the ADPCM 666/111/55 kHz chain requires.
- Sits between the system cen and the sound sub-blocks (FM, SSG, ADPCM-A/B, timers).

Parameters:
- CH, 4, number of output channels (1..16).
- W, 8, divider register / counter width in bits.
- CASCADE, 0, CH-bit mask. Bit i=1 means channel i counts ticks of channel i-1 instead of cen. Bit 0 is ignored.
- RST_DIV, 0, W-bit divide value loaded into every channel at reset. Period = RST_DIV+1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- cen  input  1  master clock enable, one-cycle pulses.
- wr  input  1  divider write strobe.
- wr_ch  input  4  target channel of write.
- wr_div  input  W  new divide value. Period = wr_div+1 source pulses.
- wr_now  input  1  1 = apply immediately and restart counter; 0 = apply at next wrap.
- sync  input  1  restart all channel counters (phase alignment).
- cen_out  output  CH  per-channel clock-enable pulses, registered.
- pending  output  CH  per-channel flag: a deferred divider value is waiting for wrap.

Behaviour:
- Reset (rst_n=0 at a rising edge), applies to every channel:
  - cnt=0, div=RST_DIV, pend_val=0, pending=0, cen_out=0.
  - Reset mid-operation discards any pending write. cen_out is low from the edge after rst_n is sampled low.
- Source pulse per channel:
  - src[0]=cen.
  - src[i] = CASCADE[i] ? tick[i-1] : cen.
  - tick[i] = src[i] & (cnt[i]==0). This is combinational, so a cascade adds no latency.
- Output: cen_out[i] <= tick[i]. Latency is 1 clk from the cen edge that caused it. Pulse width is exactly 1 clk.
- Counter, on src[i]: cnt <= (cnt==div) ? 0 : cnt+1. W-bit unsigned; never exceeds div.
- div=0: every source pulse gives a tick.
- First source pulse after reset or sync gives a tick (cnt starts at 0).
- Deferred write (wr & !wr_now & wr_ch<CH):
  - pend_val <= wr_div, pending[ch] <= 1.
  - At the next wrap (src & cnt==div): div <= pend_val, pending <= 0, cnt <= 0. The new period starts cleanly, with no short or long glitch period.
  - A second deferred write before the wrap overwrites pend_val.
- Immediate write (wr & wr_now & wr_ch<CH): div <= wr_div, cnt <= 0, pending <= 0 in the same edge. This overrides a simultaneous wrap or a pending value.
- Write with wr_ch>=CH: ignored, no state change.
- sync=1: all cnt <= 0; div and pending are kept.
  - tick in that cycle is still evaluated from the old cnt, so a cen coinciding with sync at cnt==0 still produces cen_out.
  - sync has priority over counting but not over an immediate write; both reset cnt, so the result is identical.
- Simultaneous wrap and deferred write to the same channel:
  - The wrap consumes the OLD pend_val if pending was already 1; the new value becomes pending.
  - If pending was 0, the wrap uses the current div and the new value becomes pending.
- Cascaded channel i:
  - Its counter advances only on tick[i-1].
  - A write or sync on channel i-1 alters the phase of i but never produces a spurious tick.
- No behaviour depends on cen spacing. Back-to-back cen (cen held 1) is legal and divides clk directly.

Test Plan:
- Reset, CH=4, RST_DIV=0, cen every 3 clks -> each cen_out pulses 1 clk after every cen; pending=0.
- Deferred write ch0 wr_div=5 while div=0, cen held 1 -> pending[0]=1 until the wrap edge, then cen_out[0] every 6 clks; first post-change interval exactly 6.
- CASCADE=4'b0110, div ch0=11, ch1=5, ch2=1, cen held 1 -> ch1 pulses every 72 clks, ch2 every 144. ch1 pulse coincides with a ch0 pulse; ch2 coincides with ch1.
- Immediate write ch3 wr_div=2 mid-count (cnt=4 of div 7) -> next cen gives a tick; then period 3; pending[3]=0.
- sync asserted with channels at random phases, cen held 1 -> all cen_out align on the cycle after sync+1; wr_ch=9 write ignored.
- rst_n low for 1 clk while pending[1]=1 and counters mid-period -> cen_out=0, pending=0, div=RST_DIV afterwards; first cen after reset ticks all non-cascaded channels.
